// File: rtl/lcd_i2c_target_if.sv
// Processor-side register port of lcd_i2c_target plus I2C write notification,
// bus status and a debug view of the protocol state.
interface lcd_i2c_target_if;
  // A write happens on every clk with chipselect && !write_n (no wait states).
  // readdata is reg[address] registered, valid 1 clk after address.
  // i2c_wr_strobe is a 1-clk valid with no ready; i2c_wr_index qualifies it.
  logic [2:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       i2c_wr_strobe;
  logic [2:0] i2c_wr_index;
  logic       busy;
  logic [3:0] dbg_state;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, i2c_wr_strobe, i2c_wr_index, busy, dbg_state
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, i2c_wr_strobe, i2c_wr_index, busy, dbg_state
  );
endinterface

// File: rtl/lcd_i2c_target.sv
// I2C target exposing an 8-byte register bank, shared with a local Avalon-MM port.
// Optional macro LCD_I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample filter on scl/sda.
module lcd_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            scl,
  inout  wire             sda,
  lcd_i2c_target_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_scl_s, r_sda_s;
  logic       w_scl, w_sda, r_scl_prev, r_sda_prev;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift, r_shift_out;
  logic [2:0] r_ptr, w_ptr_inc, r_wr_index;
  logic       r_sda_oe, r_strobe, r_busy;
  logic       w_byte_done, w_addr_match, w_i2c_wr, w_av_wr;
  logic [7:0] r_regs [8];
  logic [7:0] r_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
    end else begin
      r_scl_s <= {r_scl_s[0], scl};
      r_sda_s <= {r_sda_s[0], sda};
    end
  end

`ifdef LCD_I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_h, r_sda_h;
  logic       r_scl_f, r_sda_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_h <= 2'b11;
      r_sda_h <= 2'b11;
      r_scl_f <= 1'b1;
      r_sda_f <= 1'b1;
    end else begin
      r_scl_h <= {r_scl_h[0], r_scl_s[1]};
      r_sda_h <= {r_sda_h[0], r_sda_s[1]};
      r_scl_f <= w_scl;
      r_sda_f <= w_sda;
    end
  end

  // Follow the synchronizer only once the current and two previous samples agree.
  assign w_scl = (r_scl_s[1] == r_scl_h[0] && r_scl_h[0] == r_scl_h[1]) ? r_scl_s[1] : r_scl_f;
  assign w_sda = (r_sda_s[1] == r_sda_h[0] && r_sda_h[0] == r_sda_h[1]) ? r_sda_s[1] : r_sda_f;
`else
  assign w_scl = r_scl_s[1];
  assign w_sda = r_sda_s[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl_rise   = w_scl & ~r_scl_prev;
  assign w_scl_fall   = ~w_scl & r_scl_prev;
  assign w_start      = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop       = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte_done  = (r_bit_cnt == 4'd8);
  assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
  assign w_ptr_inc    = r_ptr + 3'd1;
  assign w_i2c_wr     = (r_state == S_WDATA) && w_scl_fall && w_byte_done;
  assign w_av_wr      = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_stop) begin
      w_next = S_IDLE;
    end else if (w_start) begin
      w_next = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:      if (w_scl_fall && w_byte_done) w_next = w_addr_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:  if (w_scl_fall) w_next = r_shift[0] ? S_RDATA : S_PTR;
        S_PTR:       if (w_scl_fall && w_byte_done) w_next = S_PTR_ACK;
        S_PTR_ACK:   if (w_scl_fall) w_next = S_WDATA;
        S_WDATA:     if (w_scl_fall && w_byte_done) w_next = S_WDATA_ACK;
        S_WDATA_ACK: if (w_scl_fall) w_next = S_WDATA;
        S_RDATA:     if (w_scl_fall && w_byte_done) w_next = S_RDATA_ACK;
        S_RDATA_ACK: begin
          if (w_scl_rise && w_sda) w_next = S_IDLE;
          else if (w_scl_fall)     w_next = S_RDATA;
        end
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_shift_out <= '0;
      r_ptr       <= '0;
      r_wr_index  <= '0;
      r_sda_oe    <= 1'b0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_next == S_IDLE) r_busy <= 1'b0;
      else if (r_state == S_ADDR && w_next == S_ADDR_ACK) r_busy <= 1'b1;

      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else if (w_scl_rise) begin
        if (r_state == S_ADDR || r_state == S_PTR || r_state == S_WDATA) begin
          r_shift   <= {r_shift[6:0], w_sda};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_state == S_RDATA) begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: if (w_byte_done && w_addr_match) r_sda_oe <= 1'b1;
          S_ADDR_ACK: begin
            r_bit_cnt <= '0;
            if (r_shift[0]) begin
              r_shift_out <= r_regs[r_ptr];
              r_sda_oe    <= ~r_regs[r_ptr][7];
            end else begin
              r_sda_oe <= 1'b0;
            end
          end
          S_PTR: if (w_byte_done) begin
            r_ptr    <= r_shift[2:0];
            r_sda_oe <= 1'b1;
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            r_bit_cnt <= '0;
            r_sda_oe  <= 1'b0;
          end
          S_WDATA: if (w_byte_done) begin
            r_sda_oe   <= 1'b1;
            r_strobe   <= 1'b1;
            r_wr_index <= r_ptr;
            r_ptr      <= w_ptr_inc;
          end
          S_RDATA: begin
            if (w_byte_done) begin
              r_sda_oe <= 1'b0;
            end else begin
              r_sda_oe    <= ~r_shift_out[6];
              r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
          end
          // Only reached after an ACK: a NACK already returned to idle on the rise.
          S_RDATA_ACK: begin
            r_bit_cnt   <= '0;
            r_ptr       <= w_ptr_inc;
            r_shift_out <= r_regs[w_ptr_inc];
            r_sda_oe    <= ~r_regs[w_ptr_inc][7];
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // An I2C write to the same register in the same clk overrides the Avalon write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_readdata <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_i2c_wr && r_ptr == 3'(i))             r_regs[i] <= r_shift;
        else if (w_av_wr && bus.address == 3'(i))   r_regs[i] <= bus.writedata;
      end
      r_readdata <= r_regs[bus.address];
    end
  end

  assign sda               = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.readdata      = r_readdata;
  assign bus.i2c_wr_strobe = r_strobe;
  assign bus.i2c_wr_index  = r_wr_index;
  assign bus.busy          = r_busy;
  assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_lcd_i2c_target.sv
// Bench for lcd_i2c_target: an I2C controller model, Avalon driver, and a
// scoreboard fed by a register-bank model of the target.
module tb_lcd_i2c_target;
  localparam int Q = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic tb_sda_oe = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = tb_sda_oe ? 1'b0 : 1'bz;

  lcd_i2c_target_if bus();

  lcd_i2c_target #(.DEV_ADDR(7'h3C)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (scl),
    .sda     (sda),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_regs [8];
  logic [2:0] m_ptr;
  logic [2:0] exp_wr_q [$];
  logic [7:0] exp_q [$];
  logic       obs_valid = 1'b0;
  logic [7:0] obs_data = '0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (reset_n && bus.i2c_wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_strobe: unexpected pulse with index %0d, expected none", bus.i2c_wr_index);
      end else begin
        check("wr_index", {5'd0, bus.i2c_wr_index}, {5'd0, exp_wr_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL read_data: got 0x%02h with no expected value queued", obs_data);
      end else begin
        check("read_data", obs_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic qwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic report_rd(input logic [7:0] d);
    obs_data  = d;
    obs_valid = 1'b1;
    @(negedge clk);
    obs_valid = 1'b0;
  endtask

  task automatic i2c_start();
    tb_sda_oe = 1'b0; qwait(Q);
    scl = 1'b1;       qwait(Q);
    tb_sda_oe = 1'b1; qwait(Q);
    scl = 1'b0;       qwait(Q);
  endtask

  task automatic i2c_stop();
    tb_sda_oe = 1'b1; qwait(Q);
    scl = 1'b1;       qwait(Q);
    tb_sda_oe = 1'b0; qwait(2 * Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    tb_sda_oe = ~b; qwait(Q);
    scl = 1'b1;     qwait(Q);
    if (glitch) begin
      scl = 1'b0; qwait(1);
      scl = 1'b1;
    end
    qwait(Q);
    scl = 1'b0;     qwait(Q);
  endtask

  task automatic read_bit(output logic b);
    tb_sda_oe = 1'b0; qwait(Q);
    scl = 1'b1;       qwait(Q);
    b = sda;          qwait(Q);
    scl = 1'b0;       qwait(Q);
  endtask

  // Last bit with collide set holds an Avalon write of 0x11 to reg4 across the
  // clk in which the target commits the I2C byte.
  task automatic write_byte(input logic [7:0] d, input logic glitch, input logic collide,
                            output logic ack);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      if (collide && i == 0) begin
        tb_sda_oe = ~d[0]; qwait(Q);
        scl = 1'b1;        qwait(2 * Q);
        bus.address = 3'd4; bus.writedata = 8'h11;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        qwait(1);
        scl = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          if (bus.i2c_wr_strobe) seen = 1'b1;
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        check("collide_strobe_seen", {7'd0, seen}, 8'd1);
        qwait(Q);
      end else begin
        write_bit(d[i], glitch && i == 4);
      end
    end
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack, 1'b0);
  endtask

  task automatic av_write(input logic [2:0] a, input logic [7:0] d);
    bus.address = a; bus.writedata = d;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    qwait(1);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    m_regs[a] = d;
  endtask

  task automatic av_read(input logic [2:0] a);
    bus.address = a;
    qwait(1);
    exp_q.push_back(m_regs[a]);
    report_rd(bus.readdata);
  endtask

  task automatic i2c_write_txn(input logic [7:0] addr_byte, input logic [7:0] ptr_byte, input int n,
                               input logic [31:0] data, input logic glitch, input logic collide);
    logic ack, match;
    logic [7:0] b;
    match = (addr_byte == 8'h78);
    i2c_start();
    write_byte(addr_byte, 1'b0, 1'b0, ack);
    check("addr_ack", {7'd0, ack}, {7'd0, ~match});
    check("busy_after_addr", {7'd0, bus.busy}, {7'd0, match});
    if (match) m_ptr = ptr_byte[2:0];
    write_byte(ptr_byte, 1'b0, 1'b0, ack);
    check("ptr_ack", {7'd0, ack}, {7'd0, ~match});
    for (int k = 0; k < n; k++) begin
      b = data[31 - 8 * k -: 8];
      if (match) begin
        exp_wr_q.push_back(m_ptr);
        m_regs[m_ptr] = b;
        m_ptr = m_ptr + 3'd1;
      end
      write_byte(b, glitch && k == 0, collide && k == n - 1, ack);
      check("data_ack", {7'd0, ack}, {7'd0, ~match});
    end
    i2c_stop();
    check("busy_after_stop", {7'd0, bus.busy}, 8'd0);
  endtask

  task automatic i2c_read_txn(input logic set_ptr, input logic [7:0] ptr_byte, input int n);
    logic ack;
    logic [7:0] d;
    if (set_ptr) begin
      i2c_start();
      write_byte(8'h78, 1'b0, 1'b0, ack);
      check("rd_addr_w_ack", {7'd0, ack}, 8'd0);
      write_byte(ptr_byte, 1'b0, 1'b0, ack);
      check("rd_ptr_ack", {7'd0, ack}, 8'd0);
      m_ptr = ptr_byte[2:0];
    end
    i2c_start();
    write_byte(8'h79, 1'b0, 1'b0, ack);
    check("rd_addr_r_ack", {7'd0, ack}, 8'd0);
    check("rd_busy", {7'd0, bus.busy}, 8'd1);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(m_regs[m_ptr]);
      read_byte(d, k == n - 1);
      report_rd(d);
      if (k < n - 1) m_ptr = m_ptr + 3'd1;
    end
    check("busy_after_nack", {7'd0, bus.busy}, 8'd0);
    i2c_stop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic b;
    logic [6:0] a7;
    int op;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_ptr = '0;

    qwait(5);
    reset_n = 1'b1;
    qwait(2);
    check("reset_readdata", bus.readdata, 8'h00);
    check("reset_busy", {7'd0, bus.busy}, 8'd0);
    check("reset_strobe", {7'd0, bus.i2c_wr_strobe}, 8'd0);
    check("reset_index", {5'd0, bus.i2c_wr_index}, 8'd0);
    check("reset_sda", {7'd0, sda}, 8'd1);

    // Write 0xA5, 0x5A from pointer 2, read back over Avalon.
    i2c_write_txn(8'h78, 8'h02, 2, {8'hA5, 8'h5A, 16'h0}, 1'b0, 1'b0);
    av_read(3'd3);
    av_read(3'd2);

    // Random read across the pointer wrap.
    av_write(3'd7, 8'hC3);
    av_write(3'd0, 8'h3D);
    i2c_read_txn(1'b1, 8'h07, 2);

    // Foreign address: never acked, no register change.
    i2c_write_txn(8'h7A, 8'h55, 1, {8'h99, 24'h0}, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) av_read(3'(i));

    // Simultaneous Avalon and I2C write to reg4.
    i2c_write_txn(8'h78, 8'h04, 1, {8'hEE, 24'h0}, 1'b0, 1'b1);
    av_read(3'd4);

`ifdef LCD_I2C_TARGET_GLITCH_FILTER_EN
    i2c_write_txn(8'h78, 8'h06, 1, {8'h96, 24'h0}, 1'b1, 1'b0);
    av_read(3'd6);
`endif

    // Reset in the middle of a read while the target drives a 0 bit.
    av_write(3'd5, 8'h00);
    i2c_start();
    write_byte(8'h78, 1'b0, 1'b0, b);
    write_byte(8'h05, 1'b0, 1'b0, b);
    i2c_start();
    write_byte(8'h79, 1'b0, 1'b0, b);
    check("rst_txn_ack", {7'd0, b}, 8'd0);
    for (int i = 0; i < 3; i++) read_bit(b);
    tb_sda_oe = 1'b0; qwait(Q);
    scl = 1'b1; qwait(2);
    check("rst_bit3_driven", {7'd0, sda}, 8'd0);
    reset_n = 1'b0;
    #1;
    check("rst_sda_released", {7'd0, sda}, 8'd1);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_readdata", bus.readdata, 8'h00);
    check("rst_strobe", {7'd0, bus.i2c_wr_strobe}, 8'd0);
    check("rst_index", {5'd0, bus.i2c_wr_index}, 8'd0);
    qwait(4);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_ptr = '0;
    qwait(4 * Q);
    for (int i = 0; i < 8; i++) av_read(3'(i));
    i2c_write_txn(8'h78, 8'h01, 2, {8'h12, 8'h34, 16'h0}, 1'b0, 1'b0);
    i2c_read_txn(1'b1, 8'h01, 2);

    // Randomized mix against the register-bank model.
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: i2c_write_txn(8'h78, 8'($urandom_range(0, 255)), $urandom_range(1, 4), $urandom(), 1'b0, 1'b0);
        1: i2c_read_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        2: av_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        3: av_read(3'($urandom_range(0, 7)));
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h3C) a7 = 7'h3D;
          i2c_write_txn({a7, 1'($urandom_range(0, 1))}, 8'($urandom_range(0, 255)), 1, $urandom(), 1'b0, 1'b0);
        end
      endcase
    end
    for (int i = 0; i < 8; i++) av_read(3'(i));

    qwait(20);
    check("wr_queue_drained", 8'(exp_wr_q.size()), 8'd0);
    check("rd_queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end
endmodule
